// File: rtl/hazard_fwd_ctrl_if.sv
// Decode-stage hazard/forwarding bundle: D-stage operand and producer info
// in, stall and per-stage forward selects out.
interface hazard_fwd_ctrl_if;
  logic [4:0]  rs_d;
  logic [4:0]  rt_d;
  logic [1:0]  tuse_rs;
  logic [1:0]  tuse_rt;
  logic [4:0]  wa_d;
  logic [1:0]  tnew_d;
  logic        ext_stall;
  logic        stall;
  logic [31:0] RS_D_Sel;
  logic [31:0] RT_D_Sel;
  logic [31:0] RS_E_Sel;
  logic [31:0] RT_E_Sel;
  logic [31:0] RS_M_Sel;
  logic [31:0] RT_M_Sel;

  modport master (
    output rs_d, rt_d, tuse_rs, tuse_rt, wa_d, tnew_d, ext_stall,
    input  stall, RS_D_Sel, RT_D_Sel, RS_E_Sel, RT_E_Sel, RS_M_Sel, RT_M_Sel
  );

  modport slave (
    input  rs_d, rt_d, tuse_rs, tuse_rt, wa_d, tnew_d, ext_stall,
    output stall, RS_D_Sel, RT_D_Sel, RS_E_Sel, RT_E_Sel, RS_M_Sel, RT_M_Sel
  );
endinterface

// File: rtl/hazard_fwd_ctrl.sv
// Pipeline hazard unit: Tuse/Tnew scoreboard across E/M/W, producing
// D/E/M forwarding selects and a D-stage stall. Outputs are combinational.
module hazard_fwd_ctrl #(
  parameter int unsigned E = 1,
  parameter int unsigned M = 2,
  parameter int unsigned W = 3
) (
  input logic             clk,
  input logic             rst_n,
  hazard_fwd_ctrl_if.slave bus
);

  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_E    = 2'(E);
  localparam logic [1:0] SEL_M    = 2'(M);
  localparam logic [1:0] SEL_W    = 2'(W);

  logic [4:0] wa_e, rs_e, rt_e;
  logic [1:0] tnew_e;
  logic [4:0] wa_m, rs_m, rt_m;
  logic [1:0] tnew_m;
  logic [4:0] wa_w;

  logic [1:0] tnew_d_sat;
  logic       stall_rs, stall_rt, stall_int;

  logic       hit_e_rsd, hit_m_rsd, hit_w_rsd;
  logic       hit_e_rtd, hit_m_rtd, hit_w_rtd;
  logic       hit_m_rse, hit_w_rse, hit_m_rte, hit_w_rte;
  logic       hit_w_rsm, hit_w_rtm;

  logic [1:0] rs_d_sel, rt_d_sel, rs_e_sel, rt_e_sel, rs_m_sel, rt_m_sel;

  // Producer latency saturates at 2; a code of 3 behaves like 2.
  always_comb begin
    tnew_d_sat = (bus.tnew_d == 2'd3) ? 2'd2 : bus.tnew_d;
  end

  // Scoreboard advance: E from D (or bubble on stall), M from E, W from M.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wa_e   <= '0;
      tnew_e <= '0;
      rs_e   <= '0;
      rt_e   <= '0;
      wa_m   <= '0;
      tnew_m <= '0;
      rs_m   <= '0;
      rt_m   <= '0;
      wa_w   <= '0;
    end else begin
      if (bus.stall) begin
        wa_e   <= '0;
        tnew_e <= '0;
        rs_e   <= '0;
        rt_e   <= '0;
      end else begin
        wa_e   <= bus.wa_d;
        tnew_e <= tnew_d_sat;
        rs_e   <= bus.rs_d;
        rt_e   <= bus.rt_d;
      end
      wa_m   <= wa_e;
      tnew_m <= (tnew_e == 2'd0) ? 2'd0 : tnew_e - 2'd1;
      rs_m   <= rs_e;
      rt_m   <= rt_e;
      wa_w   <= wa_m;
    end
  end

  // Register-index matches; index 0 never matches anything.
  always_comb begin
    hit_e_rsd = (bus.rs_d != '0) && (wa_e == bus.rs_d);
    hit_m_rsd = (bus.rs_d != '0) && (wa_m == bus.rs_d);
    hit_w_rsd = (bus.rs_d != '0) && (wa_w == bus.rs_d);
    hit_e_rtd = (bus.rt_d != '0) && (wa_e == bus.rt_d);
    hit_m_rtd = (bus.rt_d != '0) && (wa_m == bus.rt_d);
    hit_w_rtd = (bus.rt_d != '0) && (wa_w == bus.rt_d);
    hit_m_rse = (rs_e != '0) && (wa_m == rs_e);
    hit_w_rse = (rs_e != '0) && (wa_w == rs_e);
    hit_m_rte = (rt_e != '0) && (wa_m == rt_e);
    hit_w_rte = (rt_e != '0) && (wa_w == rt_e);
    hit_w_rsm = (rs_m != '0) && (wa_w == rs_m);
    hit_w_rtm = (rt_m != '0) && (wa_w == rt_m);
  end

  // Forward selects: youngest matching stage decides; a not-yet-ready
  // young producer blocks older (stale) copies from being forwarded.
  always_comb begin
    rs_d_sel = SEL_NONE;
    rt_d_sel = SEL_NONE;
    rs_e_sel = SEL_NONE;
    rt_e_sel = SEL_NONE;
    rs_m_sel = SEL_NONE;
    rt_m_sel = SEL_NONE;

    if (hit_e_rsd)      rs_d_sel = (tnew_e == 2'd0) ? SEL_E : SEL_NONE;
    else if (hit_m_rsd) rs_d_sel = (tnew_m == 2'd0) ? SEL_M : SEL_NONE;
    else if (hit_w_rsd) rs_d_sel = SEL_W;

    if (hit_e_rtd)      rt_d_sel = (tnew_e == 2'd0) ? SEL_E : SEL_NONE;
    else if (hit_m_rtd) rt_d_sel = (tnew_m == 2'd0) ? SEL_M : SEL_NONE;
    else if (hit_w_rtd) rt_d_sel = SEL_W;

    if (hit_m_rse)      rs_e_sel = (tnew_m == 2'd0) ? SEL_M : SEL_NONE;
    else if (hit_w_rse) rs_e_sel = SEL_W;

    if (hit_m_rte)      rt_e_sel = (tnew_m == 2'd0) ? SEL_M : SEL_NONE;
    else if (hit_w_rte) rt_e_sel = SEL_W;

    if (hit_w_rsm) rs_m_sel = SEL_W;
    if (hit_w_rtm) rt_m_sel = SEL_W;
  end

  // Stall when the youngest E/M producer of a needed operand is later than its use.
  always_comb begin
    stall_rs = 1'b0;
    stall_rt = 1'b0;
    if (bus.tuse_rs != 2'd3) begin
      if (hit_e_rsd)      stall_rs = (tnew_e > bus.tuse_rs);
      else if (hit_m_rsd) stall_rs = (tnew_m > bus.tuse_rs);
    end
    if (bus.tuse_rt != 2'd3) begin
      if (hit_e_rtd)      stall_rt = (tnew_e > bus.tuse_rt);
      else if (hit_m_rtd) stall_rt = (tnew_m > bus.tuse_rt);
    end
    stall_int = stall_rs | stall_rt | bus.ext_stall;
  end

  // Output drive, zero-extended select codes.
  always_comb begin
    bus.stall    = stall_int;
    bus.RS_D_Sel = {30'd0, rs_d_sel};
    bus.RT_D_Sel = {30'd0, rt_d_sel};
    bus.RS_E_Sel = {30'd0, rs_e_sel};
    bus.RT_E_Sel = {30'd0, rt_e_sel};
    bus.RS_M_Sel = {30'd0, rs_m_sel};
    bus.RT_M_Sel = {30'd0, rt_m_sel};
  end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl with hand-computed expected selects/stall.
module tb_hazard_fwd_ctrl;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  hazard_fwd_ctrl_if bus ();

  hazard_fwd_ctrl #(.E(1), .M(2), .W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs, input logic [1:0] tu_rs,
                       input logic [4:0] rt, input logic [1:0] tu_rt,
                       input logic [4:0] wa, input logic [1:0] tn);
    bus.rs_d    = rs;
    bus.tuse_rs = tu_rs;
    bus.rt_d    = rt;
    bus.tuse_rt = tu_rt;
    bus.wa_d    = wa;
    bus.tnew_d  = tn;
    #2;
  endtask

  task automatic idle();
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      idle();
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    bus.ext_stall = 1'b0;
    #1;
    idle();
    check("rst_stall", 32'(bus.stall), 32'd0);
    check("rst_rs_d_sel", bus.RS_D_Sel, 32'd0);
    check("rst_rt_e_sel", bus.RT_E_Sel, 32'd0);
    check("rst_rs_m_sel", bus.RS_M_Sel, 32'd0);
    bus.ext_stall = 1'b1;
    #1;
    check("rst_ext_stall", 32'(bus.stall), 32'd1);
    bus.ext_stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    flush();

    // ALU producer, one-cycle use distance
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd8, 2'd1);
    next_cycle();
    drive(5'd8, 2'd1, 5'd0, 2'd3, 5'd0, 2'd0);
    check("alu_stall", 32'(bus.stall), 32'd0);
    check("alu_rs_d_sel", bus.RS_D_Sel, 32'd0);
    next_cycle();
    idle();
    check("alu_rs_e_sel", bus.RS_E_Sel, 32'd2);
    next_cycle();
    idle();
    check("alu_rs_m_sel", bus.RS_M_Sel, 32'd3);
    flush();

    // Load-use on rt: two stall cycles, then forward from W
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd9, 2'd2);
    next_cycle();
    drive(5'd0, 2'd3, 5'd9, 2'd0, 5'd0, 2'd0);
    check("lu_stall1", 32'(bus.stall), 32'd1);
    check("lu_rt_d_sel1", bus.RT_D_Sel, 32'd0);
    next_cycle();
    check("lu_stall2", 32'(bus.stall), 32'd1);
    check("lu_rt_d_sel2", bus.RT_D_Sel, 32'd0);
    next_cycle();
    #2;
    check("lu_stall3", 32'(bus.stall), 32'd0);
    check("lu_rt_d_sel3", bus.RT_D_Sel, 32'd3);
    flush();

    // jal-style producer ready in E
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd31, 2'd0);
    next_cycle();
    drive(5'd31, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0);
    check("jal_rs_d_sel", bus.RS_D_Sel, 32'd1);
    check("jal_stall", 32'(bus.stall), 32'd0);
    flush();

    // Register 0 never matches
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd2);
    next_cycle();
    drive(5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0);
    check("r0_stall", 32'(bus.stall), 32'd0);
    check("r0_rs_d_sel", bus.RS_D_Sel, 32'd0);
    check("r0_rt_d_sel", bus.RT_D_Sel, 32'd0);
    flush();

    // Double writer: youngest (E) wins over M
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd5, 2'd1);
    next_cycle();
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd5, 2'd0);
    next_cycle();
    drive(5'd5, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0);
    check("dbl_rs_d_sel", bus.RS_D_Sel, 32'd1);
    check("dbl_stall", 32'(bus.stall), 32'd0);
    flush();

    // tnew_d=3 saturates to 2: stalls one cycle for tuse=1
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd12, 2'd3);
    next_cycle();
    drive(5'd12, 2'd1, 5'd0, 2'd3, 5'd0, 2'd0);
    check("t3_stall1", 32'(bus.stall), 32'd1);
    next_cycle();
    check("t3_stall2", 32'(bus.stall), 32'd0);
    check("t3_rs_d_sel", bus.RS_D_Sel, 32'd0);
    flush();

    // rt forwarded from M at D, then from W at E
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd7, 2'd0);
    next_cycle();
    idle();
    next_cycle();
    drive(5'd0, 2'd3, 5'd7, 2'd2, 5'd0, 2'd0);
    check("m_rt_d_sel", bus.RT_D_Sel, 32'd2);
    next_cycle();
    idle();
    check("w_rt_e_sel", bus.RT_E_Sel, 32'd3);
    flush();

    // External stall inserts a bubble instead of the D producer
    bus.ext_stall = 1'b1;
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd4, 2'd0);
    check("ext_stall", 32'(bus.stall), 32'd1);
    next_cycle();
    bus.ext_stall = 1'b0;
    drive(5'd4, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0);
    check("ext_bubble_sel", bus.RS_D_Sel, 32'd0);
    flush();

    // Reset mid load-use stall clears immediately; first edge loads D normally
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd9, 2'd2);
    next_cycle();
    drive(5'd0, 2'd3, 5'd9, 2'd0, 5'd0, 2'd0);
    check("rr_stall_pre", 32'(bus.stall), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rr_stall_async", 32'(bus.stall), 32'd0);
    check("rr_rt_d_sel", bus.RT_D_Sel, 32'd0);
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd6, 2'd0);
    rst_n = 1'b1;
    next_cycle();
    drive(5'd6, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0);
    check("rr_post_rs_d_sel", bus.RS_D_Sel, 32'd1);
    check("rr_post_stall", 32'(bus.stall), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
